operand_fetch_seq: RTL and testbench

Sequences operand fetch from the single-read-port register file between decode and execute. Takes a decoded instruction carrying a 2-bit read-select code, then issues one or two register-file reads. Captures the operands, with write-back bypass, and presents them to execute over a valid/ready handshake. Also counts execute back-pressure cycles for debug.

---
 rtl/opfetch_pkg.sv | 31 +++
 rtl/operand_fetch_seq_capture.sv | 40 ++++
 rtl/operand_fetch_seq.sv | 134 +++++++++++++
 tb/tb_operand_fetch_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opfetch_pkg.sv
// Shared types and constants for the operand fetch sequencer.
package opfetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StWait,
    StOut
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_AB   = 2'b11;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // First state after accepting an instruction with the given read select.
  function automatic state_e first_state(input logic [1:0] sel);
    state_e st;
    unique case (sel)
      SEL_A, SEL_AB: st = StRdA;
      SEL_B:         st = StRdB;
      SEL_NONE:      st = StOut;
      default:       st = StOut;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/operand_fetch_seq_capture.sv
// Single operand register: cleared on accept, loaded from read data or a
// write-back value caught during the read-issue cycle.
module opfetch_capture #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byp_hit,
  input  logic [DATA_W-1:0] byp_data,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] q
);

  logic              byp_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      q_q        <= '0;
    end else begin
      if (byp_hit) begin
        byp_q      <= 1'b1;
        byp_data_q <= byp_data;
      end
      if (cap_en) begin
        // The register file returned pre-write data; prefer the caught write.
        q_q   <= byp_q ? byp_data_q : rf_data;
        byp_q <= 1'b0;
      end
    end
  end

  assign q = q_q;

endmodule

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: one or two reads from a single-port register file,
// write-back bypass, valid/ready hand-off to execute and a stall counter.
module operand_fetch_seq
  import opfetch_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [OP_W-1:0]   dec_opcode,
  input  logic [ADDR_W-1:0] dec_r1,
  input  logic [ADDR_W-1:0] dec_r2,
  input  logic [1:0]        dec_sel,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_opcode,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic [15:0]       stall_cnt
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   opcode_q;
  logic [ADDR_W-1:0] r1_q, r2_q;
  logic [1:0]        sel_q;
  logic [15:0]       stall_q;

  logic accept;
  logic cap_a, cap_b;
  logic byp_hit;

  assign accept  = dec_valid && dec_ready;
  assign byp_hit = rf_en && wb_en && (wb_addr == rf_addr);

  always_comb begin
    state_d   = state_q;
    dec_ready = 1'b0;
    rf_en     = 1'b0;
    rf_addr   = '0;
    ex_valid  = 1'b0;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    unique case (state_q)
      StIdle: begin
        dec_ready = 1'b1;
        if (dec_valid) state_d = first_state(dec_sel);
      end
      StRdA: begin
        rf_en   = 1'b1;
        rf_addr = r1_q;
        state_d = sel_q[1] ? StRdB : StWait;
      end
      StRdB: begin
        rf_en   = 1'b1;
        rf_addr = r2_q;
        cap_a   = sel_q[0];  // data from the preceding A read lands now
        state_d = StWait;
      end
      StWait: begin
        cap_a   = !sel_q[1];
        cap_b   = sel_q[1];
        state_d = StOut;
      end
      StOut: begin
        ex_valid = 1'b1;
        if (ex_ready) begin
          dec_ready = 1'b1;
          state_d   = dec_valid ? first_state(dec_sel) : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      sel_q    <= SEL_NONE;
      stall_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opcode_q <= dec_opcode;
        r1_q     <= dec_r1;
        r2_q     <= dec_r2;
        sel_q    <= dec_sel;
      end
      if (ex_valid && !ex_ready && (stall_q != STALL_MAX)) stall_q <= stall_q + 16'd1;
    end
  end

  opfetch_capture #(
    .DATA_W (DATA_W)
  ) u_cap_a (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .byp_hit  (byp_hit && (state_q == StRdA)),
    .byp_data (wb_data),
    .cap_en   (cap_a),
    .rf_data  (rf_data),
    .q        (ex_opa)
  );

  opfetch_capture #(
    .DATA_W (DATA_W)
  ) u_cap_b (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .byp_hit  (byp_hit && (state_q == StRdB)),
    .byp_data (wb_data),
    .cap_en   (cap_b),
    .rf_data  (rf_data),
    .q        (ex_opb)
  );

  assign ex_opcode = opcode_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Bench for operand_fetch_seq: directed scenarios plus random traffic checked
// against a transaction-level model with its own register file.
module tb_operand_fetch_seq;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic          dec_ready;
  logic [OW-1:0] dec_opcode;
  logic [AW-1:0] dec_r1, dec_r2;
  logic [1:0]    dec_sel;
  logic          rf_en;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          ex_valid;
  logic          ex_ready;
  logic [OW-1:0] ex_opcode;
  logic [DW-1:0] ex_opa, ex_opb;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  operand_fetch_seq #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .OP_W   (OW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_opcode (dec_opcode),
    .dec_r1     (dec_r1),
    .dec_r2     (dec_r2),
    .dec_sel    (dec_sel),
    .rf_en      (rf_en),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_opcode  (ex_opcode),
    .ex_opa     (ex_opa),
    .ex_opb     (ex_opb),
    .stall_cnt  (stall_cnt)
  );

  // Register file environment: read data one cycle later, pre-write on collision.
  logic [DW-1:0] rf [16];
  always @(posedge clk) begin
    if (rf_en) rf_data <= rf[rf_addr];
    if (wb_en) rf[wb_addr] <= wb_data;
  end

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level reference state.
  int            cyc = 0;
  bit            m_busy = 0;
  bit            m_acc;
  int            m_ready_at = 0;
  int            m_rda = -1;
  int            m_rdb = -1;
  logic [AW-1:0] m_r1, m_r2;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_opa, m_opb;
  logic [DW-1:0] m_rf [16];
  int unsigned   m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit dv, input logic [OW-1:0] op,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [1:0] s,
                      input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit er);
    bit            v, rdy, exp_en;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    rst = r; dec_valid = dv; dec_opcode = op; dec_r1 = a1; dec_r2 = a2; dec_sel = s;
    wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = er;
    #1;
    m_acc = 0;
    if (r) begin
      m_busy = 0;
      m_cnt  = 0;
    end else begin
      v        = m_busy && (cyc >= m_ready_at);
      rdy      = !m_busy || (v && er);
      exp_en   = m_busy && (cyc == m_rda || cyc == m_rdb);
      exp_addr = !m_busy ? '0 : (cyc == m_rda) ? m_r1 : (cyc == m_rdb) ? m_r2 : '0;
      check("dec_ready", 32'(dec_ready), 32'(rdy));
      check("ex_valid", 32'(ex_valid), 32'(v));
      check("rf_en", 32'(rf_en), 32'(exp_en));
      check("rf_addr", 32'(rf_addr), 32'(exp_addr));
      check("stall_cnt", 32'(stall_cnt), m_cnt);
      if (v) begin
        check("ex_opcode", 32'(ex_opcode), 32'(m_op));
        check("ex_opa", 32'(ex_opa), 32'(m_opa));
        check("ex_opb", 32'(ex_opb), 32'(m_opb));
      end
      // An operand equals the register value including any write in its read cycle.
      if (m_busy && cyc == m_rda) m_opa = (we && wa == m_r1) ? wd : m_rf[m_r1];
      if (m_busy && cyc == m_rdb) m_opb = (we && wa == m_r2) ? wd : m_rf[m_r2];
      if (v && !er && m_cnt < 32'hFFFF) m_cnt++;
      if (v && er) m_busy = 0;
      if (dv && rdy) begin
        m_acc = 1; m_busy = 1; m_op = op; m_r1 = a1; m_r2 = a2;
        m_opa = '0; m_opb = '0; m_rda = -1; m_rdb = -1;
        case (s)
          2'b00: m_ready_at = cyc + 1;
          2'b01: begin m_rda = cyc + 1; m_ready_at = cyc + 3; end
          2'b10: begin m_rdb = cyc + 1; m_ready_at = cyc + 3; end
          default: begin m_rda = cyc + 1; m_rdb = cyc + 2; m_ready_at = cyc + 4; end
        endcase
      end
    end
    if (we) m_rf[wa] = wd;
    cyc++;
  endtask

  task automatic idle(input bit er);
    step(0, 0, '0, '0, '0, 2'b00, 0, '0, '0, er);
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [1:0] s, input bit er);
    step(0, 1, op, a1, a2, s, 0, '0, '0, er);
  endtask

  initial begin
    bit            pend;
    bit            dv, we, er;
    logic [OW-1:0] op;
    logic [AW-1:0] a1, a2, wa;
    logic [1:0]    s;
    logic [DW-1:0] wd;

    rst = 1; dec_valid = 0; dec_opcode = '0; dec_r1 = '0; dec_r2 = '0; dec_sel = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; ex_ready = 0;
    step(1, 0, '0, '0, '0, 2'b00, 0, '0, '0, 0);
    step(1, 0, '0, '0, '0, 2'b00, 0, '0, '0, 0);
    idle(1);
    check("rst_opcode", 32'(ex_opcode), 32'h0);
    check("rst_opa", 32'(ex_opa), 32'h0);
    check("rst_opb", 32'(ex_opb), 32'h0);

    for (int i = 0; i < 16; i++) begin
      wd = (i == 3) ? 16'h1234 : (i == 5) ? 16'hBEEF : (i == 7) ? 16'h0000 : DW'($urandom);
      step(0, 0, '0, '0, '0, 2'b00, 1, AW'(i), wd, 1);
    end

    // Two-operand fetch followed by a back-to-back single-operand fetch.
    issue(6'h05, 4'd3, 4'd5, 2'b11, 1);
    idle(1);
    check("t1_rd_a", 32'(rf_addr), 32'd3);
    idle(1);
    check("t1_rd_b", 32'(rf_addr), 32'd5);
    idle(1);
    check("t1_not_yet", 32'(ex_valid), 32'd0);
    issue(6'h11, 4'd5, 4'd0, 2'b01, 1);
    check("t1_valid", 32'(ex_valid), 32'd1);
    check("t1_opa", 32'(ex_opa), 32'h1234);
    check("t1_opb", 32'(ex_opb), 32'hBEEF);
    check("t1_b2b_ready", 32'(dec_ready), 32'd1);
    idle(1);
    idle(1);
    idle(1);
    check("t1b_opa", 32'(ex_opa), 32'hBEEF);
    check("t1b_opb", 32'(ex_opb), 32'h0);

    // No-operand instruction.
    issue(6'h3F, 4'd9, 4'd10, 2'b00, 1);
    idle(1);
    check("t2_valid", 32'(ex_valid), 32'd1);
    check("t2_opcode", 32'(ex_opcode), 32'h3F);
    check("t2_opa", 32'(ex_opa), 32'h0);

    // Write-back colliding with the B read.
    issue(6'h01, 4'd0, 4'd7, 2'b10, 1);
    step(0, 0, '0, '0, '0, 2'b00, 1, 4'd7, 16'hA5A5, 1);
    idle(1);
    idle(1);
    check("t3_bypass", 32'(ex_opb), 32'hA5A5);

    // Back-pressure and saturation.
    step(1, 0, '0, '0, '0, 2'b00, 0, '0, '0, 0);
    issue(6'h22, 4'd3, 4'd0, 2'b01, 0);
    idle(0);
    idle(0);
    for (int i = 0; i < 5; i++) step(0, 1, 6'h2A, 4'd1, 4'd2, 2'b00, 0, '0, '0, 0);
    idle(1);
    check("t4_stall5", 32'(stall_cnt), 32'd5);
    check("t4_opa", 32'(ex_opa), 32'h1234);
    issue(6'h2B, 4'd0, 4'd0, 2'b00, 1);
    for (int i = 0; i < 65540; i++) idle(0);
    idle(1);
    check("t4_sat", 32'(stall_cnt), 32'hFFFF);

    // Reset during the B read.
    issue(6'h0C, 4'd3, 4'd5, 2'b11, 1);
    idle(1);
    step(1, 0, '0, '0, '0, 2'b00, 0, '0, '0, 1);
    idle(1);
    check("t5_valid", 32'(ex_valid), 32'd0);
    check("t5_ready", 32'(dec_ready), 32'd1);
    check("t5_opa", 32'(ex_opa), 32'h0);
    check("t5_opb", 32'(ex_opb), 32'h0);
    check("t5_cnt", 32'(stall_cnt), 32'h0);
    issue(6'h0D, 4'd5, 4'd0, 2'b01, 1);
    idle(1);
    idle(1);
    idle(1);
    check("t5_refetch", 32'(ex_opa), 32'hBEEF);

    // Random traffic; decode holds an offered instruction until accepted.
    pend = 0;
    dv = 0; op = '0; a1 = '0; a2 = '0; s = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        dv = ($urandom % 3) != 0;
        op = OW'($urandom);
        a1 = ($urandom % 2) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        a2 = ($urandom % 2) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        s  = 2'($urandom);
      end
      we = $urandom % 2;
      wa = ($urandom % 2) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wd = DW'($urandom);
      er = ($urandom % 4) != 0;
      if ($urandom % 250 == 0) begin
        step(1, 0, '0, '0, '0, 2'b00, 0, '0, '0, er);
        pend = 0;
      end else begin
        step(0, dv, op, a1, a2, s, we, wa, wd, er);
        pend = dv && !m_acc;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
